// File: rtl/aes128_key_schedule_seq.sv
// AES-128 key expansion: one round key per clock into an 11-entry bank, done 10 cycles after start.
// No backpressure: start is ignored while expanding; the read port returns rk[rd_addr] one cycle later.
module aes128_key_schedule_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_in,
   input  logic         start,
   input  logic [3:0]   rd_addr,
   output logic [127:0] rk_out,
   output logic         busy,
   output logic         keys_valid
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] base;
      base = 11'd2047 - {x, 3'b000};
      return SBOX_TBL[base -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t        state, state_nxt;
   logic [3:0]    r;
   logic [3:0]    src;
   logic [127:0]  rk [0:10];
   logic [127:0]  prev;
   logic [127:0]  nxt;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot, sub, t;
   logic [31:0]   n0, n1, n2, n3;
   logic          load_key;
   logic          write_exp;

   assign src  = r - 4'd1;
   assign prev = (r != 4'd0 && r <= 4'd10) ? rk[src] : '0;
   assign {w0, w1, w2, w3} = prev;
   assign rot  = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      assign sub[8*g +: 8] = sbox(rot[8*g +: 8]);
   end

   assign t   = sub ^ {rcon(r), 24'h0};
   assign n0  = w0 ^ t;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;
   assign nxt = {n0, n1, n2, n3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_key  = 1'b0;
      write_exp = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = EXPAND;
               load_key  = 1'b1;
            end
         end
         EXPAND: begin
            write_exp = 1'b1;
            if (r == 4'd10) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Flags follow the next state so they are flops aligned with the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r          <= '0;
         busy       <= 1'b0;
         keys_valid <= 1'b0;
         rk_out     <= '0;
         for (int k = 0; k < 11; k++) begin
            rk[k] <= '0;
         end
      end else begin
         busy       <= (state_nxt == EXPAND);
         keys_valid <= (state_nxt == DONE);
         if (load_key) begin
            rk[0] <= key_in;
            r     <= 4'd1;
         end else if (write_exp) begin
            rk[r] <= nxt;
            r     <= r + 4'd1;
         end
         rk_out <= (rd_addr <= 4'd10) ? rk[rd_addr] : '0;
      end
   end

endmodule

// File: doc/aes128_key_schedule_seq.md
# aes128_key_schedule_seq

Sequential AES-128 key-expansion unit that generates all eleven round keys from a 128-bit cipher key, one round key per clock, and holds them in an internal bank. It sits directly upstream of the unrolled decryption datapath and supplies its round keys: rk[10] for the initial AddRoundKey, rk[9] down to rk[1] for the inverse rounds, and rk[0] for the final XOR. A registered random-access read port lets the consumer fetch keys in any order, including the reverse order decryption needs.

## Interface
- Parameters: none. The block is AES-128 only, with Nr = 10 fixed.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  128  cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96]
- start  in  1  single-cycle request to expand key_in
- rd_addr  in  4  round-key index 0..10
- rk_out  out  128  round key rk[rd_addr], registered
- busy  out  1  high while expansion is in progress
- keys_valid  out  1  high when rk[0..10] all belong to the last accepted key

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset enters IDLE.
- IDLE or DONE with start=1:
  - key_in is captured into rk[0].
  - The round counter r is set to 1.
  - The state moves to EXPAND.
  - keys_valid is cleared.
- EXPAND, each cycle, writes rk[r] from rk[r-1] = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon[r],24'h0}
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}
  - SubWord applies the forward AES S-box to each byte. There are four S-box instances, local to this block.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2; rk[r] = {n0,n1,n2,n3}.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, taken from a constant table indexed by r (no doubling logic required).
  - r increments. When r = 10 is written, the state moves to DONE.
- DONE: keys_valid = 1 and busy = 0. The bank holds its contents until the next accepted start or reset.
- start while in EXPAND is ignored. It is neither queued nor a restart.
- Read port: each cycle rk_out <= rk[rd_addr] when rd_addr ≤ 10, else 128'h0.
  - Reads are legal in any state.
  - During EXPAND, a read returns the current bank content. rk[k] is meaningful once written. Stale or zero entries are not flagged.
  - A read of an entry that is being written in the same cycle returns the old value.
- Reset (asynchronous, at any time including mid-EXPAND):
  - state = IDLE, r = 0, all rk[k] = 0.
  - rk_out = 0, busy = 0, keys_valid = 0.

## Timing
- Edge E0 samples start = 1 in IDLE or DONE. After E0: busy = 1, rk[0] is loaded, keys_valid = 0.
- Edges E1..E10 write rk[1]..rk[10], one per edge.
- After E10: busy = 0 and keys_valid = 1.
- Total latency from start to keys_valid is 10 cycles after the start cycle. Throughput is one key per 11 cycles.
- Read latency is 1 cycle: rd_addr sampled at edge N appears on rk_out after edge N.
- busy and keys_valid are never high simultaneously. Both are registered outputs, with no combinational path from inputs.
- Critical path: S-box, then the 4-deep XOR chain on the 32-bit words. No multi-cycle paths.

## Test plan
- FIPS-197 A.1 vector:
  - Stimulus: key_in = 2b7e151628aed2a6abf7158809cf4f3c, pulse start.
  - keys_valid must rise exactly 10 cycles after the start cycle.
  - Read 1 must return rk1 = a0fafe1788542cb123a339392a6c7605.
  - Read 10 must return rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Read 0 must return the key itself.
- All-zero key:
  - Read 1 must return rk1 = 62636363626363636263636362636363.
  - Read 10 must return rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start ignored while busy:
  - Stimulus: pulse a second start with a different key_in at E4.
  - Required: final rk10 still matches the first key, and keys_valid still rises after E10.
- Restart from DONE:
  - Stimulus: after the A.1 expansion, start with the zero key.
  - Required: keys_valid drops the next cycle, and rk10 becomes b4ef…188e 10 cycles later.
- Reset mid-expansion:
  - Stimulus: assert rst_n = 0 asynchronously at E5.
  - Required: busy, keys_valid and rk_out go to 0 immediately. After release, every read including rd_addr = 0 returns 0.
- Read port boundaries:
  - Reverse sweep: rd_addr 10→0 returns each key 1 cycle later.
  - rd_addr = 11 and 15 return 0.
  - Reading rd_addr = 3 at E3 returns the old value, and the new value from E4 onward.
